// File: rtl/gsm_arb_pkg.sv
// Shared types and constants for the GSM modem TX line arbiter and its helpers.
package gsm_arb_pkg;

    // Line ownership phases.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        GUARD = 2'd2
    } arb_state_t;

    // Arbitration mode selectors for RR_MODE.
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage : gsm_arb_pkg

// File: rtl/gsm_arb_pick.sv
// Combinational winner picker: fixed priority (lowest index) or round-robin
// search starting at ptr and wrapping modulo N_CH. Shared with the RX mux.
module gsm_arb_pick
    import gsm_arb_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int IDW  = (N_CH < 2) ? 1 : $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            rr_mode,
    output logic [IDW-1:0]  winner,
    output logic            found
);

    logic [IDW-1:0] base_s;
    logic [IDW-1:0] idx_s;
    int             sum_s;

    // Scan channels from the start point; the first eligible one wins.
    always_comb begin
        found  = 1'b0;
        winner = {IDW{1'b0}};
        base_s = rr_mode ? ptr : {IDW{1'b0}};
        sum_s  = 0;
        idx_s  = {IDW{1'b0}};
        for (int k = 0; k < N_CH; k++) begin
            sum_s = int'(base_s) + k;
            sum_s = (sum_s >= N_CH) ? (sum_s - N_CH) : sum_s;
            idx_s = IDW'(sum_s);
            if (!found && req[idx_s]) begin
                found  = 1'b1;
                winner = idx_s;
            end else begin
                found  = found;
                winner = winner;
            end
        end
    end

endmodule : gsm_arb_pick

// File: rtl/gsm_tx_arbiter.sv
// N-channel arbiter for the shared GSM modem UART TX line. One sender owns
// the line for a whole message, followed by a forced idle-high guard gap.
// A watchdog revokes a stuck owner and locks it out until it drops enable.
module gsm_tx_arbiter
    import gsm_arb_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int RR_MODE     = ARB_FIXED,
    parameter int GUARD_CYC   = 5208,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int IDW         = (N_CH < 2) ? 1 : $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] ch_en,
    input  logic [N_CH-1:0] ch_tx,
    input  logic [N_CH-1:0] ch_mask,
    output logic            line_tx,
    output logic            grant_valid,
    output logic [IDW-1:0]  grant_id,
    output logic            busy,
    output logic            timeout_pulse
);

    localparam int             CNT_MAX    = (GUARD_CYC > TIMEOUT_CYC) ? GUARD_CYC : TIMEOUT_CYC;
    localparam int             CW         = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0]  CNT_SAT    = {CW{1'b1}};
    localparam logic [CW-1:0]  GUARD_LAST = CW'(GUARD_CYC - 1);
    localparam logic [CW-1:0]  TMO_LAST   = CW'(TIMEOUT_CYC - 1);
    localparam logic           RR_SEL     = (RR_MODE == ARB_RR) ? 1'b1 : 1'b0;

    arb_state_t      state_r,   state_nx_s;
    logic [CW-1:0]   cnt_r,     cnt_nx_s;
    logic [IDW-1:0]  ptr_r,     ptr_nx_s;
    logic [N_CH-1:0] lockout_r, lockout_nx_s;
    logic            line_tx_r, line_nx_s;
    logic            gv_r,      gv_nx_s;
    logic [IDW-1:0]  gid_r,     gid_nx_s;
    logic            busy_r,    busy_nx_s;
    logic            tmo_r,     tmo_nx_s;

    logic [N_CH-1:0] req_s;
    logic [IDW-1:0]  win_s;
    logic            found_s;
    logic [CW-1:0]   cnt_inc_s;

    // A channel may compete only when enabled, unmasked and not locked out.
    always_comb begin
        req_s     = ch_en & ch_mask & ~lockout_r;
        cnt_inc_s = (cnt_r == CNT_SAT) ? cnt_r : (cnt_r + {{(CW-1){1'b0}}, 1'b1});
    end

    gsm_arb_pick #(
        .N_CH (N_CH),
        .IDW  (IDW)
    ) u_pick (
        .req     (req_s),
        .ptr     (ptr_r),
        .rr_mode (RR_SEL),
        .winner  (win_s),
        .found   (found_s)
    );

    // Next-state, counter, lockout and output decode for the ownership FSM.
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        ptr_nx_s     = ptr_r;
        lockout_nx_s = lockout_r & ch_en;
        line_nx_s    = 1'b1;
        gv_nx_s      = gv_r;
        gid_nx_s     = gid_r;
        tmo_nx_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_nx_s = OWN;
                    gv_nx_s    = 1'b1;
                    gid_nx_s   = win_s;
                    cnt_nx_s   = {CW{1'b0}};
                    if (RR_SEL) begin
                        ptr_nx_s = (win_s == IDW'(N_CH - 1)) ? {IDW{1'b0}}
                                                             : (win_s + {{(IDW-1){1'b0}}, 1'b1});
                    end else begin
                        ptr_nx_s = ptr_r;
                    end
                end else begin
                    gv_nx_s = 1'b0;
                end
            end
            OWN: begin
                if (!ch_en[gid_r]) begin
                    state_nx_s = GUARD;
                    gv_nx_s    = 1'b0;
                    cnt_nx_s   = {CW{1'b0}};
                end else if (cnt_r >= TMO_LAST) begin
                    state_nx_s            = GUARD;
                    gv_nx_s               = 1'b0;
                    cnt_nx_s              = {CW{1'b0}};
                    tmo_nx_s              = 1'b1;
                    lockout_nx_s[gid_r]   = 1'b1;
                end else begin
                    line_nx_s = ch_tx[gid_r];
                    cnt_nx_s  = cnt_inc_s;
                end
            end
            GUARD: begin
                if (cnt_r >= GUARD_LAST) begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = {CW{1'b0}};
                end else begin
                    cnt_nx_s = cnt_inc_s;
                end
            end
            default: begin
                state_nx_s = IDLE;
                gv_nx_s    = 1'b0;
                cnt_nx_s   = {CW{1'b0}};
            end
        endcase
        busy_nx_s = (state_nx_s != IDLE);
    end

    // State, counters, lockout and registered outputs; synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            ptr_r     <= {IDW{1'b0}};
            lockout_r <= {N_CH{1'b0}};
            line_tx_r <= 1'b1;
            gv_r      <= 1'b0;
            gid_r     <= {IDW{1'b0}};
            busy_r    <= 1'b0;
            tmo_r     <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            ptr_r     <= ptr_nx_s;
            lockout_r <= lockout_nx_s;
            line_tx_r <= line_nx_s;
            gv_r      <= gv_nx_s;
            gid_r     <= gid_nx_s;
            busy_r    <= busy_nx_s;
            tmo_r     <= tmo_nx_s;
        end
    end

    assign line_tx       = line_tx_r;
    assign grant_valid   = gv_r;
    assign grant_id      = gid_r;
    assign busy          = busy_r;
    assign timeout_pulse = tmo_r;

endmodule : gsm_tx_arbiter

// File: tb/tb_gsm_tx_arbiter.sv
// Self-checking bench: a fixed-priority and a round-robin instance share
// stimulus; a cycle model pushes expected outputs into a scoreboard queue
// before each edge, popped and compared after it. Scenario checks on top.
module tb_gsm_tx_arbiter;

    localparam int G   = 8;
    localparam int TMO = 1000;

    typedef struct {
        int         m;
        logic       line;
        logic       gv;
        logic [1:0] gid;
        logic       busy;
        logic       tmo;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ch_en, ch_tx, ch_mask;
    logic [1:0] d_line, d_gv, d_busy, d_tmo;
    logic [1:0] d_gid [2];

    int   n_checks = 0;
    int   n_pass   = 0;
    bit   tx_rand  = 1'b0;
    exp_t sb_q[$];

    // Model state: 0 idle, 1 owning, 2 guard. age = cycles owned so far,
    // left = guard cycles still to run.
    int         ms_st   [2];
    int         ms_age  [2];
    int         ms_left [2];
    int         ms_ptr  [2];
    logic [3:0] ms_lock [2];
    logic       mo_line [2];
    logic       mo_gv   [2];
    logic [1:0] mo_gid  [2];
    logic       mo_busy [2];
    logic       mo_tmo  [2];

    always #5 clk = ~clk;

    gsm_tx_arbiter #(.N_CH(4), .RR_MODE(0), .GUARD_CYC(G), .TIMEOUT_CYC(TMO)) dut_fp (
        .clk(clk), .rst(rst), .ch_en(ch_en), .ch_tx(ch_tx), .ch_mask(ch_mask),
        .line_tx(d_line[0]), .grant_valid(d_gv[0]), .grant_id(d_gid[0]),
        .busy(d_busy[0]), .timeout_pulse(d_tmo[0])
    );

    gsm_tx_arbiter #(.N_CH(4), .RR_MODE(1), .GUARD_CYC(G), .TIMEOUT_CYC(TMO)) dut_rr (
        .clk(clk), .rst(rst), .ch_en(ch_en), .ch_tx(ch_tx), .ch_mask(ch_mask),
        .line_tx(d_line[1]), .grant_valid(d_gv[1]), .grant_id(d_gid[1]),
        .busy(d_busy[1]), .timeout_pulse(d_tmo[1])
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Predict outputs after the coming edge for instance m (0 fixed, 1 rr).
    task automatic model_edge(input int m);
        logic [3:0] req;
        int         win;
        int         c;
        bit         hit;
        if (rst) begin
            ms_st[m] = 0; ms_age[m] = 0; ms_left[m] = 0; ms_ptr[m] = 0;
            ms_lock[m] = 4'b0000;
            mo_line[m] = 1'b1; mo_gv[m] = 1'b0; mo_gid[m] = 2'd0;
            mo_busy[m] = 1'b0; mo_tmo[m] = 1'b0;
        end else begin
            req        = ch_en & ch_mask & ~ms_lock[m];
            ms_lock[m] = ms_lock[m] & ch_en;
            mo_tmo[m]  = 1'b0;
            mo_line[m] = 1'b1;
            if (ms_st[m] == 0) begin
                hit = 1'b0; win = 0;
                for (int k = 0; k < 4; k++) begin
                    c = (m == 1) ? ((ms_ptr[m] + k) % 4) : k;
                    if (!hit && req[c]) begin hit = 1'b1; win = c; end
                end
                if (hit) begin
                    ms_st[m] = 1; ms_age[m] = 1; mo_gv[m] = 1'b1; mo_gid[m] = 2'(win);
                    if (m == 1) ms_ptr[m] = (win + 1) % 4;
                end
            end else if (ms_st[m] == 1) begin
                if (!ch_en[mo_gid[m]]) begin
                    ms_st[m] = 2; ms_left[m] = G; mo_gv[m] = 1'b0;
                end else if (ms_age[m] == TMO) begin
                    ms_st[m] = 2; ms_left[m] = G; mo_gv[m] = 1'b0; mo_tmo[m] = 1'b1;
                    ms_lock[m][mo_gid[m]] = 1'b1;
                end else begin
                    ms_age[m]++;
                    mo_line[m] = ch_tx[mo_gid[m]];
                end
            end else begin
                ms_left[m]--;
                if (ms_left[m] == 0) ms_st[m] = 0;
            end
            mo_busy[m] = (ms_st[m] != 0);
        end
    endtask

    // One clock: predict, push, advance, then pop and compare every output.
    task automatic step();
        exp_t  e;
        string p;
        if (tx_rand) ch_tx = 4'($urandom);
        for (int m = 0; m < 2; m++) begin
            model_edge(m);
            e.m = m; e.line = mo_line[m]; e.gv = mo_gv[m]; e.gid = mo_gid[m];
            e.busy = mo_busy[m]; e.tmo = mo_tmo[m];
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            p = (e.m == 0) ? "fp" : "rr";
            check({p, ".line_tx"},     d_line[e.m], e.line);
            check({p, ".grant_valid"}, d_gv[e.m],   e.gv);
            check({p, ".grant_id"},    d_gid[e.m],  e.gid);
            check({p, ".busy"},        d_busy[e.m], e.busy);
            check({p, ".timeout"},     d_tmo[e.m],  e.tmo);
        end
    endtask

    // Step until instance m shows a grant, bounded.
    task automatic wait_grant(input int m, input int bound, output int n);
        n = 0;
        while (d_gv[m] !== 1'b1 && n < bound) begin
            step();
            n++;
        end
        check("wait_grant", d_gv[m], 1'b1);
    endtask

    // Count idle cycles after an owner drop until instance 0 grants again.
    task automatic measure_gap(output int n, output int lows);
        n = 0; lows = 0;
        while (d_gv[0] !== 1'b1 && n < 50) begin
            if (d_line[0] !== 1'b1) lows++;
            step();
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        int lows;
        int cnt;
        int order [5];

        rst = 1'b1; ch_en = 4'b0000; ch_mask = 4'b1111; ch_tx = 4'b1111;
        repeat (3) step();
        check("rst.line_tx", d_line[0], 1'b1);
        check("rst.grant_valid", d_gv[0], 1'b0);
        check("rst.grant_id", d_gid[0], 2'd0);
        check("rst.busy", d_busy[0], 1'b0);
        rst = 1'b0;
        tx_rand = 1'b1;

        // Fixed priority: 1010 -> channel 1, then channel 3 after the gap.
        ch_en = 4'b1010;
        step();
        check("t1.grant_id", d_gid[0], 2'd1);
        check("t1.grant_valid", d_gv[0], 1'b1);
        for (int i = 0; i < 20; i++) begin
            step();
            check("t1.follow", d_line[0], ch_tx[1]);
        end
        ch_en = 4'b1000;
        step();
        measure_gap(n, lows);
        check("t1.gap", n, G + 1);
        check("t1.idle_high", lows, 0);
        check("t1.next_gid", d_gid[0], 2'd3);

        // Round-robin: all requesting, 100-cycle messages.
        ch_en = 4'b0000;
        repeat (20) step();
        ch_en = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(1, 50, n);
            order[i] = int'(d_gid[1]);
            repeat (99) step();
            ch_en = 4'b1111 & ~(4'b0001 << d_gid[1]);
            step();
            ch_en = 4'b1111;
        end
        for (int i = 0; i < 5; i++) begin
            check("rr.order", order[i], i % 4);
            if (i > 0) check("rr.no_repeat", order[i] != order[i-1], 1);
        end

        // No preemption: channel 2 keeps the line while 0 also requests.
        ch_en = 4'b0000;
        repeat (20) step();
        ch_en = 4'b0100;
        wait_grant(0, 20, n);
        check("np.first", d_gid[0], 2'd2);
        ch_en = 4'b0101;
        repeat (30) step();
        check("np.hold_gid", d_gid[0], 2'd2);
        check("np.hold_gv", d_gv[0], 1'b1);
        ch_en = 4'b0001;
        step();
        measure_gap(n, lows);
        check("np.gap", n, G + 1);
        check("np.next_gid", d_gid[0], 2'd0);

        // Watchdog: channel 0 stuck high.
        ch_en = 4'b0000;
        repeat (20) step();
        ch_en = 4'b0001;
        wait_grant(0, 20, n);
        cnt = 0;
        while (d_tmo[0] !== 1'b1 && cnt < 1200) begin
            if (d_gv[0] === 1'b1) cnt++;
            step();
        end
        check("wd.own_cycles", cnt, TMO);
        check("wd.revoked", d_gv[0], 1'b0);
        step();
        check("wd.pulse_one", d_tmo[0], 1'b0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (d_gv[0] === 1'b1) cnt++;
        end
        check("wd.locked_out", cnt, 0);
        ch_en = 4'b0000;
        step();
        ch_en = 4'b0001;
        wait_grant(0, 20, n);
        check("wd.regrant", d_gid[0], 2'd0);

        // Mask: masked request is ignored until its mask bit is set.
        ch_en = 4'b0000;
        repeat (20) step();
        ch_mask = 4'b1110;
        ch_en = 4'b0001;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (d_busy[0] !== 1'b0 || d_line[0] !== 1'b1) cnt++;
        end
        check("mask.quiet", cnt, 0);
        ch_mask = 4'b1111;
        step();
        check("mask.grant_valid", d_gv[0], 1'b1);
        check("mask.grant_id", d_gid[0], 2'd0);

        // Reset in the middle of a message driving 0.
        tx_rand = 1'b0;
        ch_tx = 4'b0000;
        repeat (5) step();
        check("mr.line_low", d_line[0], 1'b0);
        ch_en = 4'b1111;
        rst = 1'b1;
        step();
        check("mr.line_tx", d_line[0], 1'b1);
        check("mr.grant_valid", d_gv[1], 1'b0);
        check("mr.busy", d_busy[1], 1'b0);
        rst = 1'b0;
        step();
        check("mr.ptr_zero", d_gid[1], 2'd0);
        check("mr.regrant", d_gv[1], 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_gsm_tx_arbiter
